// File: rtl/tm1638_arb_pkg.sv
// -----------------------------------------------------------------------------
// tm1638_arb_pkg
// Shared types and helpers for the TM1638 display arbiter.
//   state_t  : arbiter FSM states {IDLE, OWN, SWITCH}
//   w_seg    : segment bus width (hgfedcba)
//   max_req  : largest supported requester count
//   w_idx    : width of a requester index
//   rr_next  : round-robin selection of the first request after 'last'
// -----------------------------------------------------------------------------
package tm1638_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        OWN    = 2'd1,
        SWITCH = 2'd2
    } state_t;

    localparam int w_seg   = 8;
    localparam int max_req = 8;
    localparam int w_idx   = 3;

    // Returns the first requester strictly after 'last', wrapping n-1 -> 0.
    // 'last' itself is considered only after every other requester.
    // If no request is set, 'last' is returned unchanged.
    // The scan runs from the farthest candidate to the nearest, so the
    // nearest set request is the one that survives.
    function automatic logic [w_idx-1:0] rr_next(
        input logic [max_req-1:0] req,
        input logic [w_idx-1:0]   last,
        input int                 n
    );
        logic [w_idx-1:0] pick;
        logic [w_idx-1:0] idx;
        pick = last;
        for (int k = n; k >= 1; k--) begin
            idx = w_idx'((int'(last) + k) % n);
            if (req[idx]) begin
                pick = idx;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/tm1638_display_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// tm1638_display_arbiter_rr_pick
// Combinational round-robin picker, usable by any small arbiter.
// Ports:
//   req  in  n_req  request vector
//   last in  w_idx  index of the previous winner
//   pick out w_idx  first requester after 'last' (wrapping)
//   any  out 1      at least one request is set
// -----------------------------------------------------------------------------
module tm1638_display_arbiter_rr_pick
    import tm1638_arb_pkg::*;
#(
    parameter int n_req = 2
) (
    input  logic [n_req-1:0] req,
    input  logic [w_idx-1:0] last,
    output logic [w_idx-1:0] pick,
    output logic             any
);

    logic [max_req-1:0] req_pad;

    always_comb begin
        req_pad              = '0;
        req_pad[n_req-1:0]   = req;
    end

    assign pick = rr_next(req_pad, last, n_req);
    assign any  = |req;

endmodule

// File: rtl/tm1638_display_arbiter.sv
// -----------------------------------------------------------------------------
// tm1638_display_arbiter
// Shares one TM1638 board (8 digits, 8 LEDs) among n_req requesters with a
// round-robin grant and a minimum ownership timeslice. The owner's segment,
// digit and LED data are registered and driven to tm1638_board_controller.
// Ports:
//   clk, rst (async, active-high)
//   req          in  n_req          level request per requester
//   hgfedcba_in  in  n_req*8        segments, requester i at [i*8 +: 8]
//   digit_in     in  n_req*w_digit  digit enables, requester i at [i*w_digit +: w_digit]
//   led_in       in  n_req*w_led    LEDs, requester i at [i*w_led +: w_led]
//   gnt          out n_req          registered one-hot grant
//   owner_valid  out 1              |gnt
//   hgfedcba, digit, led  out       registered owner data (0 when no owner)
// Configuration macro: TM1638_ARB_OWNER_LED_EN
//   defined     : led[n_req-1:0] shows the grant, upper bits the owner's LEDs
//   not defined : led is the owner's full led_in slice
// -----------------------------------------------------------------------------
module tm1638_display_arbiter
    import tm1638_arb_pkg::*;
#(
    parameter int clk_mhz  = 27,
    parameter int n_req    = 2,
    parameter int w_digit  = 8,
    parameter int w_led    = 8,
    parameter int slice_ms = 1000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [n_req-1:0]           req,
    input  logic [n_req*w_seg-1:0]     hgfedcba_in,
    input  logic [n_req*w_digit-1:0]   digit_in,
    input  logic [n_req*w_led-1:0]     led_in,
    output logic [n_req-1:0]           gnt,
    output logic                       owner_valid,
    output logic [w_seg-1:0]           hgfedcba,
    output logic [w_digit-1:0]         digit,
    output logic [w_led-1:0]           led
);

    localparam int SLICE = clk_mhz * 1000 * slice_ms;
    localparam int W_CNT = $clog2(SLICE + 1);
    localparam logic [W_CNT-1:0] SLICE_M1 = W_CNT'(SLICE - 1);

    if (n_req < 2 || n_req > max_req) begin : g_bad_n_req
        $error("tm1638_display_arbiter: n_req must be 2..8");
    end

    state_t             state_q, state_d;
    logic [n_req-1:0]   gnt_q, gnt_d;
    logic [w_idx-1:0]   last_q, last_d;
    logic [W_CNT-1:0]   cnt_q, cnt_d;
    logic [w_seg-1:0]   seg_q, seg_d;
    logic [w_digit-1:0] digit_q, digit_d;
    logic [w_led-1:0]   led_q, led_d;

    logic [w_idx-1:0]   pick;
    logic               any_req;
    logic [n_req-1:0]   pick_oh;
    logic               owner_req;
    logic               other_req;
    logic [n_req-1:0]   stable_gnt;

    // Per-requester views of the packed input buses.
    logic [w_seg-1:0]   seg_arr   [n_req];
    logic [w_digit-1:0] digit_arr [n_req];
    logic [w_led-1:0]   led_arr   [n_req];

    for (genvar gi = 0; gi < n_req; gi++) begin : g_unpack
        assign seg_arr[gi]   = hgfedcba_in[gi*w_seg +: w_seg];
        assign digit_arr[gi] = digit_in[gi*w_digit +: w_digit];
        assign led_arr[gi]   = led_in[gi*w_led +: w_led];
    end

    tm1638_display_arbiter_rr_pick #(
        .n_req (n_req)
    ) u_rr_pick (
        .req  (req),
        .last (last_q),
        .pick (pick),
        .any  (any_req)
    );

    always_comb begin
        pick_oh = '0;
        for (int i = 0; i < n_req; i++) begin
            pick_oh[i] = (pick == w_idx'(i));
        end
    end

    // While owning, gnt_q is the owner's one-hot, so masking req with it
    // separates the owner's request from everybody else's.
    assign owner_req = |(req & gnt_q);
    assign other_req = |(req & ~gnt_q);

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    gnt_d   = pick_oh;
                    last_d  = pick;
                    cnt_d   = SLICE_M1;
                    state_d = OWN;
                end
            end
            OWN: begin
                if (!owner_req) begin
                    gnt_d   = '0;
                    state_d = SWITCH;
                end else if (cnt_q == '0) begin
                    // Slice used up: rotate only if somebody else is waiting,
                    // otherwise keep the grant with the counter parked at 0.
                    if (other_req) begin
                        gnt_d   = '0;
                        state_d = SWITCH;
                    end
                end else begin
                    cnt_d = cnt_q - W_CNT'(1);
                end
            end
            SWITCH: begin
                if (any_req) begin
                    gnt_d   = pick_oh;
                    last_d  = pick;
                    cnt_d   = SLICE_M1;
                    state_d = OWN;
                end else begin
                    gnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // Data is taken only from a requester whose grant is held both this cycle
    // and the next. Every ownership change passes through gnt=0, so the
    // outputs blank on the cycle the grant drops and stay blank on the first
    // cycle of a new grant: two owners' data can never overlap.
    assign stable_gnt = gnt_q & gnt_d;

    always_comb begin
        seg_d   = '0;
        digit_d = '0;
        led_d   = '0;
        for (int i = 0; i < n_req; i++) begin
            if (stable_gnt[i]) begin
                seg_d   = seg_arr[i];
                digit_d = digit_arr[i];
                led_d   = led_arr[i];
            end
        end
`ifdef TM1638_ARB_OWNER_LED_EN
        // Low LEDs become an owner indicator.
        for (int i = 0; i < n_req; i++) begin
            led_d[i] = stable_gnt[i];
        end
`endif
    end

`ifdef TM1638_ARB_OWNER_LED_EN
    if (n_req > w_led) begin : g_bad_led_width
        $error("tm1638_display_arbiter: owner LED indicator needs n_req <= w_led");
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            last_q  <= w_idx'(n_req - 1);
            cnt_q   <= '0;
            seg_q   <= '0;
            digit_q <= '0;
            led_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            seg_q   <= seg_d;
            digit_q <= digit_d;
            led_q   <= led_d;
        end
    end

    assign gnt         = gnt_q;
    assign owner_valid = |gnt_q;
    assign hgfedcba    = seg_q;
    assign digit       = digit_q;
    assign led         = led_q;

endmodule
